// File: rtl/dmem_io_ctrl.sv
// Data-side memory/IO controller behind the single-cycle core: word RAM, board
// output registers, synchronized switches and a prescaled timer with sticky tick flag.
module dmem_io_ctrl #(
  parameter int DMEM_BYTES = 2048,
  parameter int SW_W       = 18,
  parameter int LEDR_W     = 18,
  parameter int LEDG_W     = 9,
  parameter int PRESCALE   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_we,
  input  logic              dmem_re,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  input  logic [SW_W-1:0]   i_sw,
  output logic [LEDR_W-1:0] o_ledr,
  output logic [LEDG_W-1:0] o_ledg,
  output logic [31:0]       o_hex_lo,
  output logic [31:0]       o_hex_hi
);

  localparam int AW    = $clog2(DMEM_BYTES);
  localparam int DEPTH = DMEM_BYTES / 4;
  localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [31:0] ADDR_LEDR   = 32'h1000_0000;
  localparam logic [31:0] ADDR_LEDG   = 32'h1000_1000;
  localparam logic [31:0] ADDR_HEX_LO = 32'h1000_2000;
  localparam logic [31:0] ADDR_HEX_HI = 32'h1000_3000;
  localparam logic [31:0] ADDR_SW     = 32'h1001_0000;
  localparam logic [31:0] ADDR_TIMER  = 32'h1002_0000;
  localparam logic [31:0] ADDR_TSTAT  = 32'h1002_0004;

  logic [31:0]     mem [DEPTH];
  logic [AW-3:0]   ram_idx;
  logic            sel_ram, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi;
  logic            sel_sw, sel_timer, sel_tstat;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [PW-1:0]   presc;
  logic [31:0]     timer;
  logic            sticky;
  logic            tick;
  logic            unused_addr;

  assign unused_addr = ^dmem_addr[1:0];
  assign ram_idx     = dmem_addr[AW-1:2];

  assign sel_ram    = (dmem_addr[31:AW] == '0);
  assign sel_ledr   = (dmem_addr[31:2] == ADDR_LEDR[31:2]);
  assign sel_ledg   = (dmem_addr[31:2] == ADDR_LEDG[31:2]);
  assign sel_hex_lo = (dmem_addr[31:2] == ADDR_HEX_LO[31:2]);
  assign sel_hex_hi = (dmem_addr[31:2] == ADDR_HEX_HI[31:2]);
  assign sel_sw     = (dmem_addr[31:2] == ADDR_SW[31:2]);
  assign sel_timer  = (dmem_addr[31:2] == ADDR_TIMER[31:2]);
  assign sel_tstat  = (dmem_addr[31:2] == ADDR_TSTAT[31:2]);

  assign tick = (presc == PRE_MAX);

  // Reads always see pre-edge state, so a same-cycle write is never forwarded.
  always_comb begin
    dmem_rdata = '0;
    if (dmem_re) begin
      if (sel_ram)         dmem_rdata = mem[ram_idx];
      else if (sel_ledr)   dmem_rdata = 32'(o_ledr);
      else if (sel_ledg)   dmem_rdata = 32'(o_ledg);
      else if (sel_hex_lo) dmem_rdata = o_hex_lo;
      else if (sel_hex_hi) dmem_rdata = o_hex_hi;
      else if (sel_sw)     dmem_rdata = 32'(sw_sync);
      else if (sel_timer)  dmem_rdata = timer;
      else if (sel_tstat)  dmem_rdata = {31'b0, sticky};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dmem_we && sel_ram) mem[ram_idx] <= dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_ledr   <= '0;
      o_ledg   <= '0;
      o_hex_lo <= 32'hFFFF_FFFF;
      o_hex_hi <= 32'hFFFF_FFFF;
      sw_meta  <= '0;
      sw_sync  <= '0;
      presc    <= '0;
      timer    <= '0;
      sticky   <= 1'b0;
    end else begin
      sw_meta <= i_sw;
      sw_sync <= sw_meta;
      presc   <= tick ? '0 : presc + PW'(1);
      if (tick) timer <= timer + 32'd1;

      // A tick in the same cycle as a clear keeps the flag set.
      if (tick) sticky <= 1'b1;
      else if (dmem_we && sel_tstat && dmem_wdata[0]) sticky <= 1'b0;

      if (dmem_we) begin
        if (sel_ledr)   o_ledr   <= dmem_wdata[LEDR_W-1:0];
        if (sel_ledg)   o_ledg   <= dmem_wdata[LEDG_W-1:0];
        if (sel_hex_lo) o_hex_lo <= dmem_wdata;
        if (sel_hex_hi) o_hex_hi <= dmem_wdata;
        if (sel_timer) begin
          timer <= dmem_wdata;
          presc <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Self-checking bench for dmem_io_ctrl: directed scenarios plus a randomized
// run compared against a cycle-count based reference model.
module tb_dmem_io_ctrl;

  localparam int P = 4;
  localparam logic [31:0] A_LEDR  = 32'h1000_0000;
  localparam logic [31:0] A_LEDG  = 32'h1000_1000;
  localparam logic [31:0] A_HLO   = 32'h1000_2000;
  localparam logic [31:0] A_HHI   = 32'h1000_3000;
  localparam logic [31:0] A_SW    = 32'h1001_0000;
  localparam logic [31:0] A_TIMER = 32'h1002_0000;
  localparam logic [31:0] A_TSTAT = 32'h1002_0004;

  logic        clk = 1'b0;
  logic        rst, dmem_we, dmem_re;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [17:0] i_sw, o_ledr;
  logic [8:0]  o_ledg;
  logic [31:0] o_hex_lo, o_hex_hi;

  dmem_io_ctrl #(.DMEM_BYTES(2048), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .i_sw(i_sw), .o_ledr(o_ledr), .o_ledg(o_ledg),
    .o_hex_lo(o_hex_lo), .o_hex_hi(o_hex_hi)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: timer value is derived from cycles elapsed since last load.
  logic [31:0] m_ram [int];
  logic [17:0] m_ledr;
  logic [8:0]  m_ledg;
  logic [31:0] m_hlo, m_hhi;
  logic [31:0] m_tload;
  int          m_cyc;
  bit          m_sticky;
  logic [17:0] m_s1, m_s2;
  logic [17:0] sw_val = '0;
  logic [31:0] got_rd, exp_rd;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'd2048) return m_ram.exists(int'(w[10:2])) ? m_ram[int'(w[10:2])] : 32'h0;
    case (w)
      A_LEDR:  return {14'b0, m_ledr};
      A_LEDG:  return {23'b0, m_ledg};
      A_HLO:   return m_hlo;
      A_HHI:   return m_hhi;
      A_SW:    return {14'b0, m_s2};
      A_TIMER: return m_tload + 32'(m_cyc / P);
      A_TSTAT: return {31'b0, m_sticky};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit we, input logic [31:0] a,
                            input logic [31:0] d, input logic [17:0] sw);
    logic [31:0] w;
    bit tick;
    w = {a[31:2], 2'b00};
    if (r) begin
      m_ledr = '0; m_ledg = '0; m_hlo = '1; m_hhi = '1;
      m_tload = '0; m_cyc = 0; m_sticky = 0; m_s1 = '0; m_s2 = '0;
      return;
    end
    tick = ((m_cyc + 1) % P) == 0;
    m_s2 = m_s1;
    m_s1 = sw;
    if (we) begin
      if (w < 32'd2048) m_ram[int'(w[10:2])] = d;
      if (w == A_LEDR) m_ledr = d[17:0];
      if (w == A_LEDG) m_ledg = d[8:0];
      if (w == A_HLO)  m_hlo = d;
      if (w == A_HHI)  m_hhi = d;
    end
    if (we && w == A_TIMER) begin
      m_tload = d;
      m_cyc = 0;
    end else begin
      m_cyc++;
    end
    if (tick) m_sticky = 1;
    else if (we && w == A_TSTAT && d[0]) m_sticky = 0;
  endtask

  // One clock cycle: drive at negedge, capture comb read data, advance model, pass edge.
  task automatic step(input bit r, input bit we, input bit re,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; dmem_we = we; dmem_re = re; dmem_addr = a; dmem_wdata = d; i_sw = sw_val;
    #1;
    got_rd = dmem_rdata;
    exp_rd = re ? model_read(a) : 32'h0;
    model_edge(r, we, a, d, sw_val);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++; if (o_ledr !== 18'h0) begin n_fail++; $display("FAIL reset_ledr got=%h exp=0", o_ledr); end
    n_tests++; if (o_ledg !== 9'h0) begin n_fail++; $display("FAIL reset_ledg got=%h exp=0", o_ledg); end
    n_tests++; if (o_hex_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_hex_lo got=%h exp=ffffffff", o_hex_lo); end
    n_tests++; if (o_hex_hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_hex_hi got=%h exp=ffffffff", o_hex_hi); end
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL reset_timer got=%h exp=0", got_rd); end
    step(0, 0, 1, A_TSTAT, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL reset_tstat got=%h exp=0", got_rd); end
  endtask

  task automatic test_ram;
    step(0, 1, 0, 32'h7FC, 32'hDEAD_BEEF);
    step(0, 1, 0, 32'h000, 32'h1234_5678);
    step(0, 0, 1, 32'h7FC, 0);
    n_tests++; if (got_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_7fc got=%h exp=deadbeef", got_rd); end
    step(0, 0, 1, 32'h000, 0);
    n_tests++; if (got_rd !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_000 got=%h exp=12345678", got_rd); end
    step(0, 0, 1, 32'h7FD, 0);
    n_tests++; if (got_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_7fd got=%h exp=deadbeef", got_rd); end
    step(0, 1, 1, 32'h7FC, 32'hA5A5_A5A5);
    n_tests++; if (got_rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rw_old got=%h exp=deadbeef", got_rd); end
    step(0, 0, 1, 32'h7FC, 0);
    n_tests++; if (got_rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ram_rw_new got=%h exp=a5a5a5a5", got_rd); end
    step(0, 0, 0, 32'h7FC, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL ram_no_re got=%h exp=0", got_rd); end
  endtask

  task automatic test_io;
    step(0, 1, 0, A_LEDR, 32'hFFFF_FFFF);
    n_tests++; if (o_ledr !== 18'h3FFFF) begin n_fail++; $display("FAIL io_ledr got=%h exp=3ffff", o_ledr); end
    step(0, 0, 1, A_LEDR, 0);
    n_tests++; if (got_rd !== 32'h0003_FFFF) begin n_fail++; $display("FAIL io_ledr_rd got=%h exp=0003ffff", got_rd); end
    step(0, 1, 0, A_LEDG, 32'hFFFF_FE5A);
    n_tests++; if (o_ledg !== 9'h05A) begin n_fail++; $display("FAIL io_ledg got=%h exp=05a", o_ledg); end
    step(0, 1, 0, A_HLO, 32'h0102_0304);
    step(0, 1, 0, A_HHI, 32'hC0F9_A4B0);
    n_tests++; if (o_hex_lo !== 32'h0102_0304 || o_hex_hi !== 32'hC0F9_A4B0) begin
      n_fail++; $display("FAIL io_hex got=%h_%h exp=c0f9a4b0_01020304", o_hex_hi, o_hex_lo); end
    step(0, 1, 0, A_SW, 32'h5555_5555);
    step(0, 1, 0, 32'h2000_0000, 32'h5555_5555);
    n_tests++; if (o_ledr !== 18'h3FFFF || o_ledg !== 9'h05A || o_hex_lo !== 32'h0102_0304) begin
      n_fail++; $display("FAIL io_ignored_wr ledr=%h ledg=%h hlo=%h", o_ledr, o_ledg, o_hex_lo); end
    step(0, 0, 1, A_SW, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL io_sw_rd got=%h exp=0", got_rd); end
    step(0, 0, 1, 32'h2000_0000, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL io_unmapped_rd got=%h exp=0", got_rd); end
    step(0, 0, 1, 32'h0000_0800, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL io_above_ram got=%h exp=0", got_rd); end
  endtask

  task automatic test_switches;
    sw_val = 18'h0;
    idle(3);
    sw_val = 18'h2AAAA;
    step(0, 0, 1, A_SW, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL sw_edge0 got=%h exp=0", got_rd); end
    step(0, 0, 1, A_SW, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL sw_edge1 got=%h exp=0", got_rd); end
    step(0, 0, 1, A_SW, 0);
    n_tests++; if (got_rd !== 32'h0002_AAAA) begin n_fail++; $display("FAIL sw_edge2 got=%h exp=0002aaaa", got_rd); end
  endtask

  task automatic test_timer;
    step(1, 0, 0, 0, 0);
    idle(8);
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd2) begin n_fail++; $display("FAIL tmr_count got=%h exp=2", got_rd); end
    step(0, 0, 1, A_TSTAT, 0);
    n_tests++; if (got_rd !== 32'd1) begin n_fail++; $display("FAIL tmr_sticky got=%h exp=1", got_rd); end
    step(0, 1, 0, A_TSTAT, 32'h1);
    step(0, 0, 1, A_TSTAT, 0);
    n_tests++; if (got_rd !== 32'd0) begin n_fail++; $display("FAIL tmr_clear got=%h exp=0", got_rd); end
    step(0, 1, 0, A_TIMER, 32'hFFFF_FFFF);
    idle(3);
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmr_pre_wrap got=%h exp=ffffffff", got_rd); end
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'h0) begin n_fail++; $display("FAIL tmr_wrap got=%h exp=0", got_rd); end
  endtask

  task automatic test_timer_write_tick;
    step(1, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, A_TIMER, 32'd5);
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd5) begin n_fail++; $display("FAIL wtick_load got=%h exp=5", got_rd); end
    idle(2);
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd5) begin n_fail++; $display("FAIL wtick_hold got=%h exp=5", got_rd); end
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd6) begin n_fail++; $display("FAIL wtick_next got=%h exp=6", got_rd); end
    step(0, 1, 0, A_TIMER, 32'd9);
    idle(3);
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd9) begin n_fail++; $display("FAIL presc_clear got=%h exp=9", got_rd); end
    step(0, 0, 1, A_TIMER, 0);
    n_tests++; if (got_rd !== 32'd10) begin n_fail++; $display("FAIL presc_after got=%h exp=10", got_rd); end
  endtask

  task automatic test_reset_mid;
    step(0, 1, 0, A_LEDR, 32'h1234);
    step(0, 1, 0, A_HLO, 32'h0);
    step(1, 1, 0, A_LEDR, 32'h3FFFF);
    n_tests++; if (o_ledr !== 18'h0) begin n_fail++; $display("FAIL rstmid_ledr got=%h exp=0", o_ledr); end
    n_tests++; if (o_hex_lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rstmid_hex got=%h exp=ffffffff", o_hex_lo); end
    step(0, 0, 1, 32'h7FC, 0);
    n_tests++; if (got_rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL rstmid_ram got=%h exp=a5a5a5a5", got_rd); end
  endtask

  task automatic test_random;
    logic [31:0] alist [10] = '{A_LEDR, A_LEDG, A_HLO, A_HHI, A_SW, A_TIMER, A_TSTAT,
                                32'h2000_0000, 32'h1000_0004, 32'h0000_0800};
    logic [31:0] a, d;
    bit r, we, re;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) sw_val = 18'($urandom);
      if ($urandom_range(0, 1) == 0)
        a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      else
        a = alist[$urandom_range(0, 9)];
      d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 49) == 0);
      step(r, we, re, a, d);
      n_tests++;
      if (got_rd !== exp_rd) begin
        n_fail++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, got_rd, exp_rd);
      end
      n_tests++;
      if (o_ledr !== m_ledr || o_ledg !== m_ledg || o_hex_lo !== m_hlo || o_hex_hi !== m_hhi) begin
        n_fail++; $display("FAIL rnd_outputs i=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
                           o_ledr, o_ledg, o_hex_lo, o_hex_hi, m_ledr, m_ledg, m_hlo, m_hhi);
      end
    end
  endtask

  initial begin
    rst = 1'b1; dmem_we = 1'b0; dmem_re = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; i_sw = '0;
    test_reset();
    test_ram();
    test_io();
    test_switches();
    test_timer();
    test_timer_write_tick();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_io_ctrl.md
Name: dmem_io_ctrl

Overview:
- Data-side memory/IO controller directly downstream of the single-cycle RV32I core's data-memory port.
- Consumes the core's dmem_we/dmem_re/dmem_addr/dmem_wdata and returns dmem_rdata in the same cycle.
- Decodes the address into on-chip data RAM, board output registers (LEDs, 7-seg), a synchronized switch input and a prescaled timer.
- Word accesses only.

Parameters:
- DMEM_BYTES, 2048, data RAM size in bytes; power of two, at least 64.
- SW_W, 18, switch input width.
- LEDR_W, 18, red LED register width.
- LEDG_W, 9, green LED register width.
- PRESCALE, 50000, clock cycles per timer tick; at least 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- dmem_we  in  1  store strobe from core
- dmem_re  in  1  load strobe from core
- dmem_addr  in  32  byte address; bits [1:0] ignored
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, combinational
- i_sw  in  SW_W  asynchronous switch inputs
- o_ledr  out  LEDR_W  red LED register
- o_ledg  out  LEDG_W  green LED register
- o_hex_lo  out  32  7-seg digits 0-3, one byte each, active-low segments in [6:0]
- o_hex_hi  out  32  7-seg digits 4-7

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Address map (word aligned, full 32-bit compare unless stated):
  - RAM: 0x0000_0000 .. DMEM_BYTES-1.
  - LEDR: 0x1000_0000 (RW).
  - LEDG: 0x1000_1000 (RW).
  - HEX_LO: 0x1000_2000 (RW).
  - HEX_HI: 0x1000_3000 (RW).
  - SW: 0x1001_0000 (RO).
  - TIMER: 0x1002_0000 (RW).
  - TSTAT: 0x1002_0004 (RW, bit0 = tick-sticky).
  - Everything else is unmapped.
- Reads:
  - dmem_rdata is combinational from the current address whenever dmem_re=1; 0 when dmem_re=0.
  - Returns the pre-edge value, including when a write to the same address is in the same cycle.
  - Narrow registers are zero-extended.
  - Unmapped address reads 0.
- Writes:
  - Take effect on the rising edge when dmem_we=1.
  - Narrow registers take the low bits of dmem_wdata.
  - Writes to SW or unmapped addresses are ignored with no side effect.
  - Both we and re in one cycle is legal: read the old value, write the new one.
- RAM:
  - Word array of DMEM_BYTES/4 entries, indexed by addr[log2(DMEM_BYTES)-1:2].
  - Contents are not cleared by reset.
- Reset values:
  - LEDR, LEDG = 0.
  - HEX_LO, HEX_HI = 0xFFFF_FFFF (all segments off).
  - TIMER = 0, prescaler = 0, sticky = 0, SW sync flops = 0.
- SW path:
  - Two-flop synchronizer.
  - The SW read reflects a change on i_sw at the 2nd rising edge after it.
- Timer:
  - Prescaler counts 0..PRESCALE-1; on reaching PRESCALE-1 it wraps to 0 and asserts a one-cycle tick.
  - On tick, TIMER increments (0xFFFF_FFFF wraps to 0) and sticky sets.
  - A TIMER write loads dmem_wdata and clears the prescaler; it takes priority over a same-cycle tick.
  - A TSTAT write with bit0=1 clears sticky; if a tick occurs in the same cycle, sticky stays 1.
- Reset mid-operation:
  - rst wins over any same-cycle write.
  - In-flight state is discarded; RAM is retained.

Test Plan:
- Reset -> o_ledr=0, o_ledg=0, o_hex_lo=o_hex_hi=0xFFFFFFFF; TIMER read=0; TSTAT read=0.
- RAM: store 0xDEADBEEF @0x7FC, then 0x12345678 @0x000. Load both -> same values. Load 0x7FD -> 0xDEADBEEF (addr[1:0] ignored). Same-cycle we+re to 0x7FC with 0xA5A5A5A5 -> rdata 0xDEADBEEF, next read 0xA5A5A5A5.
- IO: store 0xFFFFFFFF @0x1000_0000 -> o_ledr=0x3FFFF; read back 0x0003FFFF. Store @0x1001_0000 and @0x2000_0000 -> no state change; reads return SW value and 0.
- Switches: i_sw 0 -> 0x2AAAA. Read SW after 1 edge -> 0; after 2 edges -> 0x2AAAA.
- Timer with PRESCALE=4: after reset, 8 cycles -> TIMER=2, TSTAT=1. Write TSTAT=1 -> 0. Write TIMER=0xFFFFFFFF, 4 cycles -> TIMER=0.
- Write TIMER=5 coincident with a tick -> TIMER=5, prescaler restarts. rst asserted with a same-cycle LEDR write -> o_ledr=0.
